// File: rtl/bsg_mcl_request_scheduler.sv
// bsg_mcl_request_scheduler: round-robin arbiter that feeds host request queues into one credited endpoint channel, with a drain-and-wait fence
// Optional: define BSG_MCL_SCHED_STATS_EN to get per-queue 32-bit transfer counters on stats_o (otherwise stats_o is tied to 0)
module bsg_mcl_request_scheduler #(
  parameter int num_req_p = 4,
  parameter int max_out_credits_p = 16,
  localparam int credits_width_lp = $clog2(max_out_credits_p+1),
  localparam int id_width_lp = $clog2(num_req_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p-1:0][127:0]         req_data_i,
  output logic [num_req_p-1:0]                req_ready_o,
  output logic                                out_v_o,
  output logic [127:0]                        out_data_o,
  input  logic                                out_ready_i,
  input  logic [credits_width_lp-1:0]         out_credits_i,
  input  logic                                fence_i,
  output logic                                fence_done_o,
  output logic [id_width_lp-1:0]              grant_id_o,
  output logic [num_req_p-1:0][31:0]          stats_o
);
  typedef enum logic [1:0] {RUN, FENCE_WAIT, FENCE_DONE} state_e;
  state_e state_r, state_n;
  logic [id_width_lp-1:0] last_r, winner, cand;
  logic found, grant, xfer;
  assign xfer = out_v_o & out_ready_i;
  assign grant = reset_n_i && state_r == RUN && !fence_i && out_credits_i != '0 && (!out_v_o || out_ready_i) && found;
  // round-robin search starting just after the last winner
  always_comb begin
    winner = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = id_width_lp'((int'(last_r) + k) % num_req_p);
      if (!found && req_v_i[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end
  // fence state register
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= RUN;
    else state_r <= state_n;
  // fence next state: the wait only ends once the register is empty and every credit is back
  always_comb begin
    state_n = state_r;
    case (state_r)
      RUN:        state_n = fence_i ? FENCE_WAIT : RUN;
      FENCE_WAIT: state_n = (!out_v_o && out_credits_i == credits_width_lp'(max_out_credits_p)) ? FENCE_DONE : FENCE_WAIT;
      FENCE_DONE: state_n = fence_i ? FENCE_DONE : RUN;
      default:    state_n = RUN;
    endcase
  end
  // outputs decoded from the fence state and the grant decision
  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[winner] = 1'b1;
    fence_done_o = state_r == FENCE_DONE;
  end
  // output register: load on grant, empty on a transfer without a refill, hold otherwise
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      out_v_o <= 1'b0;
      out_data_o <= '0;
      grant_id_o <= '0;
      last_r <= id_width_lp'(num_req_p-1);
    end else if (grant) begin
      out_v_o <= 1'b1;
      out_data_o <= req_data_i[winner];
      grant_id_o <= winner;
      last_r <= winner;
    end else if (out_ready_i) out_v_o <= 1'b0;
`ifdef BSG_MCL_SCHED_STATS_EN
  for (genvar g = 0; g < num_req_p; g++) begin : g_stats
    logic [31:0] cnt_r;
    // count transfers of packets granted to this queue, wrapping naturally
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) cnt_r <= '0;
      else if (xfer && grant_id_o == id_width_lp'(g)) cnt_r <= cnt_r + 32'd1;
    assign stats_o[g] = cnt_r;
  end
`else
  assign stats_o = '0;
  logic unused;
  assign unused = xfer;
`endif
endmodule
